// File: rtl/decoder_proj_pkg.sv
// decoder_proj_pkg: shared widths, io_in field positions and the hex 7-segment table.
package decoder_proj_pkg;
  localparam int CODE_W = 4;
  localparam int SEG_W = 7;
  localparam int ONEHOT_W = 16;
  localparam int IO_W = 7;
  localparam int CLK_BIT = 0;
  localparam int RST_BIT = 1;
  localparam int CODE_LSB = 2;
  localparam int EN_BIT = 6;
  // Segment bits are g..a, active-high; entry 0 is the rightmost element.
  localparam logic [ONEHOT_W-1:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/decoder_proj_core.sv
// decoder_proj_core: latches a 4-bit code on enable and decodes it to one-hot and 7-segment.
module decoder_proj_core
  import decoder_proj_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CODE_W-1:0]   code,
  output logic [CODE_W-1:0]   code_q,
  output logic                valid_q,
  output logic [ONEHOT_W-1:0] onehot,
  output logic [SEG_W-1:0]    seg
);
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      code_q  <= code;
      valid_q <= 1'b1;
    end
  end
  always_comb begin
    onehot = valid_q ? ONEHOT_W'(1) << code_q : '0;
    seg    = valid_q ? SEG_TABLE[code_q] : '0;
  end
endmodule

// File: rtl/decoder_proj_fv.sv
// decoder_proj_fv: formal harness around decoder_proj_core; DECODER_PROJ_COVER_EN adds cover goals.
module decoder_proj_fv
  import decoder_proj_pkg::*;
(
  input logic [IO_W-1:0] io_in
);
  logic                clk, rst, en;
  logic [CODE_W-1:0]   code, code_q, prev_code, prev_code_q;
  logic                valid_q, prev_valid_q, prev_rst, prev_en, past_valid;
  logic [ONEHOT_W-1:0] onehot;
  logic [SEG_W-1:0]    seg;
  assign clk  = io_in[CLK_BIT];
  assign rst  = io_in[RST_BIT];
  assign en   = io_in[EN_BIT];
  assign code = io_in[CODE_LSB +: CODE_W];
  decoder_proj_core u_core (
    .clk(clk), .rst(rst), .en(en), .code(code),
    .code_q(code_q), .valid_q(valid_q), .onehot(onehot), .seg(seg)
  );
  // prev_* hold the inputs and state seen at the previous edge, standing in for $past.
  always_ff @(posedge clk) begin
    past_valid   <= 1'b1;
    prev_rst     <= rst;
    prev_en      <= en;
    prev_code    <= code;
    prev_code_q  <= code_q;
    prev_valid_q <= valid_q;
  end
  always_ff @(posedge clk) begin
    if (!past_valid) assume (rst);
    if (past_valid) begin
      assert ($onehot0(onehot));
      assert (valid_q ? onehot[code_q] : onehot == '0);
      assert (seg == (valid_q ? SEG_TABLE[code_q] : '0));
      if (prev_rst) assert (code_q == '0 && !valid_q && onehot == '0 && seg == '0);
      if (!prev_rst && prev_en) assert (code_q == prev_code && valid_q);
      if (!prev_rst && !prev_en) assert (code_q == prev_code_q && valid_q == prev_valid_q);
    end
  end
`ifdef DECODER_PROJ_COVER_EN
  for (genvar i = 0; i < ONEHOT_W; i++) begin : g_cov
    cover property (@(posedge clk) past_valid && onehot == ONEHOT_W'(1) << i);
  end
  cover property (@(posedge clk) past_valid && seg == 7'h7D);
  cover property (@(posedge clk) past_valid && prev_rst && !rst && en);
`endif
endmodule

// File: tb/tb_decoder_proj_fv.sv
// tb_decoder_proj_fv: randomized and directed scoreboard bench for the decoder harness.
module tb_decoder_proj_fv;
  typedef struct {
    logic [3:0] code;
    logic       valid;
  } exp_t;
  logic clk = 0, rst = 1, en = 0;
  logic [3:0] code = 0;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [3:0] m_code = 0;
  logic m_valid = 0;
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  decoder_proj_fv dut (.io_in({en, code, rst, clk}));

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic e, input logic [3:0] c);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; en = e; code = c;
    if (r) begin
      m_code = 0; m_valid = 0;
    end else if (e) begin
      m_code = c; m_valid = 1;
    end
    x.code = m_code; x.valid = m_valid;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [15:0] eo;
      logic [6:0] es;
      logic [15:0] ao;
      logic [6:0] as_;
      x = q.pop_front();
      eo = x.valid ? 16'(1) << x.code : 16'h0000;
      es = x.valid ? seg_tbl[x.code] : 7'h00;
      ao = dut.u_core.onehot;
      as_ = dut.u_core.seg;
      checks += 3;
      if (ao !== eo) begin
        failures++;
        $display("FAIL onehot got=%h exp=%h", ao, eo);
      end
      if (as_ !== es) begin
        failures++;
        $display("FAIL seg got=%h exp=%h", as_, es);
      end
      if (dut.u_core.valid_q !== x.valid || (x.valid && dut.u_core.code_q !== x.code)) begin
        failures++;
        $display("FAIL state got=%b/%h exp=%b/%h", dut.u_core.valid_q, dut.u_core.code_q, x.valid, x.code);
      end
    end
  end

  initial begin
    cyc(1, 0, 0);
    cyc(0, 1, 6);
    cyc(0, 0, 3);
    cyc(0, 0, 3);
    cyc(1, 1, 9);
    cyc(0, 0, 9);
    for (int c = 0; c < 16; c++) cyc(0, 1, 4'(c));
    cyc(0, 1, 15);
    cyc(0, 1, 0);
    cyc(0, 0, 5);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(15) == 0, 1'($urandom), 4'($urandom));
    cyc(0, 0, 0);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
